raw10_unpacker: RTL and testbench

Converts the 32-bit long-packet payload words produced by the CSI-2 packet receiver into RAW10 pixels, four pixels per output beat. It sits directly downstream of the packet receiver and upstream of the image pipeline.
- Consumes: `image_data`, `image_data_enable`, `image_data_type`, `word_count`.
- Produces: aligned 4-pixel groups with line-start and line-end markers.
- Words of any other data type pass through unused.

---
 rtl/raw10_unpacker.sv | 180 ++++++++++++++++++
 tb/tb_raw10_unpacker.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/raw10_unpacker.sv
// RAW10 unpacker: turns 32-bit CSI-2 long-packet payload words into aligned
// groups of four 10-bit pixels, with line-start/line-end markers.
module raw10_unpacker #(
    parameter logic [7:0] DATA_TYPE = 8'h2B
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] image_data,
    input  logic        image_data_enable,
    input  logic [7:0]  image_data_type,
    input  logic [15:0] word_count,
    output logic [39:0] pixel_data,
    output logic        pixel_enable,
    output logic        line_start,
    output logic        line_end,
    output logic        format_error
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] line_len_q, line_len_d;
    logic [16:0] bytes_rx_q, bytes_rx_d;
    logic [63:0] buf_q, buf_d;
    logic [3:0]  fill_q, fill_d;
    logic        first_q, first_d;
    logic [39:0] pixel_data_q, pixel_data_d;
    logic        pixel_enable_q, pixel_enable_d;
    logic        line_start_q, line_start_d;
    logic        line_end_q, line_end_d;
    logic        format_error_q, format_error_d;

    logic        accept_s;
    logic [15:0] len_eff_s;
    logic [16:0] rx_eff_s;
    logic [63:0] buf_eff_s;
    logic [3:0]  fill_eff_s;
    logic        first_eff_s;
    logic [16:0] remain_s;
    logic [2:0]  valid_s;
    logic [31:0] masked_s;
    logic [95:0] ext_s;
    logic [63:0] buf_app_s;
    logic [3:0]  fill_app_s;
    logic [16:0] rx_new_s;

    // Bytes B0..B4 packed as {B4,B3,B2,B1,B0}; B4 carries the two LSBs of each pixel.
    function automatic logic [39:0] unpack_group(input logic [39:0] grp);
        logic [39:0] pix;
        pix = 40'd0;
        for (int k = 0; k < 4; k++) begin
            pix[10*k +: 10] = {grp[8*k +: 8], grp[32 + 2*k +: 2]};
        end
        return pix;
    endfunction

    // Next-state: append the valid bytes of an accepted word, extract at most one group, close the packet.
    always_comb begin
        state_d        = state_q;
        line_len_d     = line_len_q;
        bytes_rx_d     = bytes_rx_q;
        buf_d          = buf_q;
        fill_d         = fill_q;
        first_d        = first_q;
        pixel_data_d   = pixel_data_q;
        pixel_enable_d = 1'b0;
        line_start_d   = 1'b0;
        line_end_d     = 1'b0;
        format_error_d = 1'b0;
        masked_s       = 32'd0;

        accept_s = image_data_enable && (image_data_type == DATA_TYPE);

        // In IDLE the word being accepted opens a new packet, so its context starts from scratch.
        if (state_q == ST_IDLE) begin
            len_eff_s   = word_count;
            rx_eff_s    = 17'd0;
            buf_eff_s   = 64'd0;
            fill_eff_s  = 4'd0;
            first_eff_s = 1'b1;
        end else begin
            len_eff_s   = line_len_q;
            rx_eff_s    = bytes_rx_q;
            buf_eff_s   = buf_q;
            fill_eff_s  = fill_q;
            first_eff_s = first_q;
        end

        remain_s = {1'b0, len_eff_s} - rx_eff_s;
        if (remain_s >= 17'd4) begin
            valid_s = 3'd4;
        end else begin
            valid_s = remain_s[2:0];
        end

        for (int i = 0; i < 4; i++) begin
            if (3'(i) < valid_s) begin
                masked_s[8*i +: 8] = image_data[8*i +: 8];
            end else begin
                masked_s[8*i +: 8] = 8'd0;
            end
        end

        ext_s      = {32'd0, buf_eff_s} | ({64'd0, masked_s} << {fill_eff_s, 3'b000});
        buf_app_s  = ext_s[63:0];
        fill_app_s = fill_eff_s + {1'b0, valid_s};
        rx_new_s   = rx_eff_s + {14'd0, valid_s};

        // A zero-length packet never leaves IDLE, so len_eff_s is non-zero whenever ACTIVE.
        if (accept_s && (len_eff_s != 16'd0)) begin
            state_d    = ST_ACTIVE;
            line_len_d = len_eff_s;
            bytes_rx_d = rx_new_s;
            first_d    = first_eff_s;
            if (fill_app_s >= 4'd5) begin
                pixel_data_d   = unpack_group(buf_app_s[39:0]);
                pixel_enable_d = 1'b1;
                line_start_d   = first_eff_s;
                first_d        = 1'b0;
                buf_d          = {40'd0, buf_app_s[63:40]};
                fill_d         = fill_app_s - 4'd5;
            end else begin
                buf_d  = buf_app_s;
                fill_d = fill_app_s;
            end
            if (rx_new_s == {1'b0, len_eff_s}) begin
                state_d        = ST_IDLE;
                bytes_rx_d     = 17'd0;
                line_end_d     = pixel_enable_d;
                format_error_d = (fill_d != 4'd0);
                buf_d          = 64'd0;
                fill_d         = 4'd0;
                first_d        = 1'b0;
            end else begin
                line_end_d = 1'b0;
            end
        end else begin
            pixel_enable_d = 1'b0;
        end
    end

    // State and registered outputs, with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            line_len_q     <= 16'd0;
            bytes_rx_q     <= 17'd0;
            buf_q          <= 64'd0;
            fill_q         <= 4'd0;
            first_q        <= 1'b0;
            pixel_data_q   <= 40'd0;
            pixel_enable_q <= 1'b0;
            line_start_q   <= 1'b0;
            line_end_q     <= 1'b0;
            format_error_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            line_len_q     <= line_len_d;
            bytes_rx_q     <= bytes_rx_d;
            buf_q          <= buf_d;
            fill_q         <= fill_d;
            first_q        <= first_d;
            pixel_data_q   <= pixel_data_d;
            pixel_enable_q <= pixel_enable_d;
            line_start_q   <= line_start_d;
            line_end_q     <= line_end_d;
            format_error_q <= format_error_d;
        end
    end

    assign pixel_data   = pixel_data_q;
    assign pixel_enable = pixel_enable_q;
    assign line_start   = line_start_q;
    assign line_end     = line_end_q;
    assign format_error = format_error_q;

endmodule

// File: tb/tb_raw10_unpacker.sv
// Scoreboard bench for raw10_unpacker: stimulus pushes expected output events,
// a negedge monitor pops and compares them against the DUT.
module tb_raw10_unpacker;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] image_data;
    logic        image_data_enable;
    logic [7:0]  image_data_type;
    logic [15:0] word_count;
    logic [39:0] pixel_data;
    logic        pixel_enable;
    logic        line_start;
    logic        line_end;
    logic        format_error;

    typedef struct packed {
        logic        pe;
        logic [39:0] data;
        logic        ls;
        logic        le;
        logic        fe;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    logic        rst_sampled = 1'b0;
    logic [39:0] last_data = 40'd0;

    raw10_unpacker #(.DATA_TYPE(8'h2B)) dut (
        .clock(clock),
        .reset(reset),
        .image_data(image_data),
        .image_data_enable(image_data_enable),
        .image_data_type(image_data_type),
        .word_count(word_count),
        .pixel_data(pixel_data),
        .pixel_enable(pixel_enable),
        .line_start(line_start),
        .line_end(line_end),
        .format_error(format_error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [39:0] got, input logic [39:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Reset value the DUT saw at the last rising edge.
    always @(posedge clock) rst_sampled <= reset;

    // Monitor: compare every output event against the scoreboard.
    always @(negedge clock) begin
        if (!rst_sampled) begin
            chk("reset_outputs", {pixel_data[35:0], pixel_enable, line_start, line_end, format_error},
                40'd0);
            chk("reset_pixel_data", pixel_data, 40'd0);
            last_data = 40'd0;
        end else if (pixel_enable === 1'b1 || format_error === 1'b1 ||
                     line_start === 1'b1 || line_end === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: pe=%b ls=%b le=%b fe=%b data=%h expected none",
                         pixel_enable, line_start, line_end, format_error, pixel_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pixel_enable", {39'd0, pixel_enable}, {39'd0, mon_e.pe});
                chk("line_start", {39'd0, line_start}, {39'd0, mon_e.ls});
                chk("line_end", {39'd0, line_end}, {39'd0, mon_e.le});
                chk("format_error", {39'd0, format_error}, {39'd0, mon_e.fe});
                if (mon_e.pe) begin
                    chk("pixel_data", pixel_data, mon_e.data);
                end
            end
            if (pixel_enable === 1'b1) begin
                last_data = pixel_data;
            end
        end else begin
            chk("pixel_data_hold", pixel_data, last_data);
        end
    end

    function automatic logic [39:0] model_unpack(input logic [7:0] b0, input logic [7:0] b1,
                                                 input logic [7:0] b2, input logic [7:0] b3,
                                                 input logic [7:0] b4);
        logic [7:0]  bytes [0:3];
        logic [39:0] r;
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
        r = 40'd0;
        for (int k = 0; k < 4; k++) begin
            r[10*k +: 10] = {bytes[k], 2'(b4 >> (2*k))};
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d, input logic [7:0] t, input logic [15:0] wc);
        image_data        = d;
        image_data_type   = t;
        word_count        = wc;
        image_data_enable = 1'b1;
        tick();
        image_data_enable = 1'b0;
    endtask

    // Send the first nsend words of a len-byte RAW10 packet and queue the expected events.
    task automatic send_line(input int len, input int nsend, input int max_gap,
                             input bit foreign, input bit hand);
        logic [7:0] b [0:63];
        exp_t       e;
        int         nwords;
        int         last_w;
        int         ngroups;
        nwords  = (len + 3) / 4;
        last_w  = nwords - 1;
        ngroups = len / 5;
        for (int i = 0; i < 64; i++) b[i] = 8'($urandom);
        if (hand) begin
            b[0] = 8'h01; b[1] = 8'h02; b[2] = 8'h03; b[3] = 8'h04; b[4] = 8'hE4;
        end
        for (int w = 0; w < nsend; w++) begin
            e = '0;
            for (int g = 0; g < ngroups; g++) begin
                if ((5*g + 4) / 4 == w) begin
                    e.pe   = 1'b1;
                    e.data = model_unpack(b[5*g], b[5*g+1], b[5*g+2], b[5*g+3], b[5*g+4]);
                    if (hand && g == 0) e.data = {10'h013, 10'h00E, 10'h009, 10'h004};
                    e.ls   = (g == 0);
                    e.le   = (w == last_w);
                end
            end
            if (w == last_w && (len % 5) != 0) e.fe = 1'b1;
            if (e.pe || e.fe) exp_q.push_back(e);
        end
        for (int w = 0; w < nsend; w++) begin
            if (w != 0) repeat ($urandom_range(0, max_gap)) tick();
            if (foreign) send_word($urandom, 8'h2A, 16'($urandom));
            send_word({b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]}, 8'h2B, 16'(len));
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        tick();
        chk(name, 40'(exp_q.size()), 40'd0);
        exp_q.delete();
    endtask

    initial begin
        reset             = 1'b0;
        image_data        = 32'd0;
        image_data_enable = 1'b0;
        image_data_type   = 8'h00;
        word_count        = 16'd0;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        send_line(20, 5, 0, 1'b0, 1'b1);
        drain("basic_drain");

        send_line(20, 5, 3, 1'b0, 1'b0);
        drain("gaps_drain");

        send_line(22, 6, 0, 1'b0, 1'b0);
        send_line(20, 5, 0, 1'b0, 1'b0);
        drain("partial_drain");

        send_word(32'hDEADBEEF, 8'h2A, 16'd20);
        send_word(32'h12345678, 8'h2A, 16'd0);
        send_line(20, 5, 1, 1'b1, 1'b0);
        drain("foreign_drain");

        send_word(32'hCAFEF00D, 8'h2B, 16'd0);
        send_line(20, 5, 0, 1'b0, 1'b0);
        drain("zero_len_drain");

        send_line(20, 3, 0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        send_line(20, 5, 0, 1'b0, 1'b0);
        drain("reset_mid_drain");

        send_line(40, 10, 0, 1'b0, 1'b0);
        send_line(40, 10, 0, 1'b0, 1'b0);
        drain("back_to_back_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
